// File: rtl/tile_stitcher_if.sv
// Tile descriptor input and pixel write-address stream of the tile stitcher.
// The master is the descriptor source / write sink; the slave is the stitcher.
interface tile_stitcher_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 32
);
    logic              tile_valid;
    logic [WIDTH-1:0]  tile_row_idx;
    logic [WIDTH-1:0]  tile_col_idx;
    logic [WIDTH-1:0]  tile_rows_in;
    logic [WIDTH-1:0]  tile_cols_in;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_first;
    logic              wr_last;

    modport master (
        output tile_valid, tile_row_idx, tile_col_idx, tile_rows_in, tile_cols_in,
        output wr_ready,
        input  wr_valid, wr_addr, wr_first, wr_last
    );

    modport slave (
        input  tile_valid, tile_row_idx, tile_col_idx, tile_rows_in, tile_cols_in,
        input  wr_ready,
        output wr_valid, wr_addr, wr_first, wr_last
    );
endinterface

// File: rtl/tile_stitcher.sv
// Buffers tile descriptors and expands each tile into per-pixel frame-buffer
// write addresses, tracking raster order and signalling the end of the frame.
module tile_stitcher #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  frame_H,
    input  logic [WIDTH-1:0]  frame_W,
    input  logic [WIDTH-1:0]  tile_rows,
    input  logic [WIDTH-1:0]  tile_cols_max,
    input  logic [ADDR_W-1:0] base_addr,
    tile_stitcher_if.slave    bus,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              order_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = (ADDR_W > 2 * WIDTH) ? ADDR_W : 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, ARMED, WALK} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] row;
        logic [WIDTH-1:0] col;
        logic [WIDTH-1:0] rows;
        logic [WIDTH-1:0] cols;
    } desc_t;

    state_t            state;
    desc_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  fh_q, fw_q, exp_row, exp_col, rows_q, cols_q, r, c;
    logic [ADDR_W-1:0] base_q, line;

    desc_t             din, head;
    logic              full, pop, push_req, push, drop, clear;
    logic              zero_size, misplaced, hs, tile_end, frame_end, col_wrap;
    logic [2*WIDTH-1:0] prod;
    logic [ADDR_W-1:0] line_load, line_next, addr_next;
    logic [WIDTH-1:0]  c_next, r_next;
    logic              last_next;
    logic [WIDTH:0]    exp_col_sum, exp_row_sum, exp_row_upd;

    // Tile-geometry hints are part of the configuration bus but the walker
    // takes each tile's size from its own descriptor.
    logic unused_cfg;
    assign unused_cfg = ^{tile_rows, tile_cols_max};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        din       = {bus.tile_row_idx, bus.tile_col_idx, bus.tile_rows_in, bus.tile_cols_in};
        head      = mem[rptr];
        full      = (count == CNT_W'(FIFO_DEPTH));
        pop       = (state == ARMED) && (count != '0);
        push_req  = (state != IDLE) && bus.tile_valid;
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        zero_size = (head.rows == '0) || (head.cols == '0);
        misplaced = (head.row != exp_row) || (head.col != exp_col);

        prod      = {{WIDTH{1'b0}}, head.row} * {{WIDTH{1'b0}}, fw_q};
        line_load = ADDR_W'(SUM_W'(base_q) + SUM_W'(prod) + SUM_W'(head.col));

        c_next    = c + WIDTH'(1);
        r_next    = r;
        line_next = line;
        if (c >= cols_q - WIDTH'(1)) begin
            c_next    = '0;
            r_next    = r + WIDTH'(1);
            line_next = line + ADDR_W'(fw_q);
        end
        addr_next = line_next + ADDR_W'(c_next);
        last_next = (r_next == rows_q - WIDTH'(1)) && (c_next == cols_q - WIDTH'(1));

        // Position bookkeeping is one bit wider so the end tests cannot wrap.
        hs          = bus.wr_valid && bus.wr_ready;
        tile_end    = (state == WALK) && hs && bus.wr_last;
        exp_col_sum = {1'b0, exp_col} + {1'b0, cols_q};
        exp_row_sum = {1'b0, exp_row} + {1'b0, rows_q};
        col_wrap    = (exp_col_sum >= {1'b0, fw_q});
        exp_row_upd = col_wrap ? exp_row_sum : {1'b0, exp_row};
        frame_end   = tile_end && (exp_row_upd >= {1'b0, fh_q});
        clear       = ((state == IDLE) && start) || frame_end;
    end

    // NOTE: descriptor storage has no reset; only pointers and count say what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            fh_q         <= '0;
            fw_q         <= '0;
            base_q       <= '0;
            exp_row      <= '0;
            exp_col      <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            r            <= '0;
            c            <= '0;
            line         <= '0;
            bus.wr_valid <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_first <= 1'b0;
            bus.wr_last  <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            order_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (drop) overflow <= 1'b1;

            if (clear) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + PTR_W'(1);
                if (pop)  rptr <= rptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        fh_q      <= frame_H;
                        fw_q      <= frame_W;
                        base_q    <= base_addr;
                        exp_row   <= '0;
                        exp_col   <= '0;
                        overflow  <= 1'b0;
                        order_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (pop) begin
                        if (misplaced || zero_size) order_err <= 1'b1;
                        // Zero-sized tiles are discarded without leaving ARMED.
                        if (!zero_size) begin
                            rows_q       <= head.rows;
                            cols_q       <= head.cols;
                            r            <= '0;
                            c            <= '0;
                            line         <= line_load;
                            bus.wr_valid <= 1'b1;
                            bus.wr_addr  <= line_load;
                            bus.wr_first <= 1'b1;
                            bus.wr_last  <= (head.rows == WIDTH'(1)) && (head.cols == WIDTH'(1));
                            state        <= WALK;
                        end
                    end
                end
                WALK: begin
                    if (hs) begin
                        if (bus.wr_last) begin
                            bus.wr_valid <= 1'b0;
                            bus.wr_first <= 1'b0;
                            bus.wr_last  <= 1'b0;
                            if (col_wrap) begin
                                exp_col <= '0;
                                exp_row <= exp_row_sum[WIDTH-1:0];
                            end else begin
                                exp_col <= exp_col_sum[WIDTH-1:0];
                            end
                            if (frame_end) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                state <= ARMED;
                            end
                        end else begin
                            c            <= c_next;
                            r            <= r_next;
                            line         <= line_next;
                            bus.wr_addr  <= addr_next;
                            bus.wr_first <= 1'b0;
                            bus.wr_last  <= last_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_stitcher.sv
// Scoreboard bench for tile_stitcher: directed tile sequences queue expected
// writes, and an independent monitor checks every write handshake.
module tb_tile_stitcher;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 32;
    localparam int FW     = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  frame_H = '0, frame_W = '0, tile_rows = '0, tile_cols_max = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, frame_done, overflow, order_err;

    tile_stitcher_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    tile_stitcher #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .frame_H       (frame_H),
        .frame_W       (frame_W),
        .tile_rows     (tile_rows),
        .tile_cols_max (tile_cols_max),
        .base_addr     (base_addr),
        .bus           (bus),
        .busy          (busy),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .order_err     (order_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              first;
        logic              last;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0, bad = 0;
    int   wr_cnt = 0, done_cnt = 0;
    int   ready_mode = 0;  // 0: always ready, 1: toggle 1,0,1,0, 2: never ready

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Write sink readiness, updated just after each rising edge.
    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.wr_ready = ~bus.wr_ready;
                2:       bus.wr_ready = 1'b0;
                default: bus.wr_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshakes are judged on the falling edge, before the edge that takes them.
    initial begin
        logic              stalled;
        logic              bubble;
        logic [ADDR_W-1:0] hold_addr;
        exp_t              e;
        stalled   = 1'b0;
        bubble    = 1'b0;
        hold_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                bubble  = 1'b0;
            end else begin
                if (stalled) check("stall_hold_addr", bus.wr_addr, hold_addr);
                if (bubble) begin
                    check("bubble_after_last", bus.wr_valid, 1'b0);
                    bubble = 1'b0;
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got addr 0x%0h, expected no write", bus.wr_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus.wr_addr, e.addr);
                        check("wr_first", bus.wr_first, e.first);
                        check("wr_last", bus.wr_last, e.last);
                    end
                    if (bus.wr_last) bubble = 1'b1;
                end
                stalled   = bus.wr_valid && !bus.wr_ready;
                hold_addr = bus.wr_addr;
                if (frame_done) done_cnt++;
            end
        end
    end

    task automatic expect_tile(input logic [ADDR_W-1:0] base0, input int rows, input int cols);
        exp_t e;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.addr  = base0 + ADDR_W'(r * FW + c);
                e.first = (r == 0) && (c == 0);
                e.last  = (r == rows - 1) && (c == cols - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_tile(input int row, input int col, input int rows, input int cols);
        bus.tile_valid   = 1'b1;
        bus.tile_row_idx = WIDTH'(row);
        bus.tile_col_idx = WIDTH'(col);
        bus.tile_rows_in = WIDTH'(rows);
        bus.tile_cols_in = WIDTH'(cols);
        @(posedge clk);
        #1;
        bus.tile_valid = 1'b0;
    endtask

    task automatic do_start(input int fh);
        frame_H       = WIDTH'(fh);
        frame_W       = WIDTH'(FW);
        tile_rows     = 16'd2;
        tile_cols_max = 16'd4;
        base_addr     = 32'h1000;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_valid"}, bus.wr_valid, 1'b0);
        check({tag, "_wr_addr"}, bus.wr_addr, '0);
        check({tag, "_wr_first"}, bus.wr_first, 1'b0);
        check({tag, "_wr_last"}, bus.wr_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_order_err"}, order_err, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (frame_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    task automatic run_full_frame(input string tag, input int mode);
        int w0, d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        ready_mode = mode;
        do_start(4);
        check({tag, "_busy_after_start"}, busy, 1'b1);
        expect_tile(32'h1000, 2, 4);
        expect_tile(32'h1004, 2, 2);
        expect_tile(32'h100C, 2, 4);
        expect_tile(32'h1010, 2, 2);
        send_tile(0, 0, 2, 4);
        check({tag, "_valid_before_pop"}, bus.wr_valid, 1'b0);
        send_tile(0, 4, 2, 2);
        check({tag, "_valid_after_pop"}, bus.wr_valid, 1'b1);
        // A start while busy must not re-latch the base address.
        start     = 1'b1;
        base_addr = 32'h2000;
        send_tile(2, 0, 2, 4);
        start     = 1'b0;
        base_addr = 32'h1000;
        send_tile(2, 4, 2, 2);
        wait_done(tag);
        repeat (3) @(negedge clk);
        check({tag, "_writes"}, wr_cnt - w0, 24);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_order_err"}, order_err, 1'b0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_end"}, busy, 1'b0);
        ready_mode = 0;
    endtask

    initial begin
        #700000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0;
        bus.tile_valid   = 1'b0;
        bus.tile_row_idx = '0;
        bus.tile_col_idx = '0;
        bus.tile_rows_in = '0;
        bus.tile_cols_in = '0;

        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Descriptor in IDLE is ignored.
        send_tile(0, 0, 2, 4);
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_wr_valid", bus.wr_valid, 1'b0);

        run_full_frame("full", 0);
        run_full_frame("bp", 1);

        // Out-of-order first tile is still walked.
        apply_reset();
        do_start(4);
        expect_tile(32'h100C, 2, 4);
        send_tile(2, 0, 2, 4);
        check("oe_before_pop", order_err, 1'b0);
        @(posedge clk);
        #1;
        check("oe_after_pop", order_err, 1'b1);
        wait_drain("oe");

        // Zero-sized tile: flagged, discarded, still ARMED.
        apply_reset();
        do_start(4);
        send_tile(0, 0, 0, 4);
        repeat (3) @(posedge clk);
        #1;
        check("zero_order_err", order_err, 1'b1);
        check("zero_wr_valid", bus.wr_valid, 1'b0);
        check("zero_busy", busy, 1'b1);
        expect_tile(32'h1000, 2, 4);
        send_tile(0, 0, 2, 4);
        wait_drain("zero");
        check("zero_busy_after", busy, 1'b1);

        // Overflow: frame of 2 rows, 1x2 tiles, sink stalled.
        apply_reset();
        ready_mode = 2;
        d0 = done_cnt;
        do_start(2);
        expect_tile(32'h1000, 1, 2);
        expect_tile(32'h1002, 1, 2);
        expect_tile(32'h1004, 1, 2);
        expect_tile(32'h1006, 1, 2);
        expect_tile(32'h1008, 1, 2);
        send_tile(0, 0, 1, 2);
        send_tile(0, 2, 1, 2);
        send_tile(0, 4, 1, 2);
        send_tile(1, 0, 1, 2);
        send_tile(1, 2, 1, 2);
        check("ovf_before_sixth", overflow, 1'b0);
        send_tile(1, 4, 1, 2);
        check("ovf_after_sixth", overflow, 1'b1);
        ready_mode = 0;
        wait_drain("ovf");
        repeat (4) @(negedge clk);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_busy", busy, 1'b1);
        check("ovf_no_done", done_cnt - d0, 0);
        expect_tile(32'h100A, 1, 2);
        send_tile(1, 4, 1, 2);
        wait_done("ovf");
        check("ovf_sticky_after_frame", overflow, 1'b1);
        do_start(2);
        check("ovf_cleared_by_start", overflow, 1'b0);

        // Reset in the middle of the first tile, then a clean frame.
        apply_reset();
        w0 = wr_cnt;
        do_start(4);
        expect_tile(32'h1000, 2, 4);
        send_tile(0, 0, 2, 4);
        send_tile(0, 4, 2, 2);
        begin
            int n = 0;
            while ((wr_cnt - w0) < 3 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("midrst_reached_walk", bus.wr_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_full_frame("after_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tile_stitcher.md
# tile_stitcher

Receiving end of the frame tiling interface. It accepts one tile descriptor per cycle (row index, column index, height, width), buffers it in a small descriptor FIFO, and expands each tile into a stream of per-pixel frame-buffer write addresses with a valid/ready handshake. It also checks that tiles arrive in raster order, covering the frame exactly, and pulses `frame_done` once the last pixel of the frame has been written.

## Interface
**Parameters**
- `WIDTH`, 16: width of dimension and index fields.
- `ADDR_W`, 32: width of the write address.
- `FIFO_DEPTH`, 4: number of descriptor FIFO entries; must be a power of 2, at least 2.

**Ports**
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `start`  in  1  arm for a new frame; ignored unless IDLE.
- `frame_H`, `frame_W`, `tile_rows`, `tile_cols_max`  in  WIDTH  frame configuration; latched on an accepted `start`.
- `base_addr`  in  ADDR_W  frame-buffer base address; latched on an accepted `start`.
- `tile_valid`  in  1  descriptor strobe; no backpressure to the source.
- `tile_row_idx`, `tile_col_idx`  in  WIDTH  tile origin.
- `tile_rows_in`, `tile_cols_in`  in  WIDTH  tile height and width.
- `wr_valid`  out  1  write address valid.
- `wr_ready`  in  1  downstream accepts the write.
- `wr_addr`  out  ADDR_W  pixel address.
- `wr_first`, `wr_last`  out  1  first / last pixel of the current tile.
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse.
- `overflow`  out  1  sticky: a descriptor was dropped because the FIFO was full.
- `order_err`  out  1  sticky: a tile was out of order or had zero size.

## Operation
- **States:** IDLE, ARMED, WALK.
- **IDLE:** descriptors are ignored and not enqueued.
  - `start` latches the configuration.
  - It clears the FIFO, `overflow`, `order_err`, and the expected position (`exp_row`, `exp_col`), all to 0.
  - Next state: ARMED.
- **Push rule:** in ARMED or WALK, `tile_valid` pushes the descriptor.
  - If the FIFO is full at the start of the cycle and no pop happens that cycle, the descriptor is dropped and `overflow` is set.
  - A push and a pop in the same cycle when full is accepted.
- **ARMED:** if the FIFO is non-empty, pop the head and load the tile.
  - If origin ≠ (`exp_row`, `exp_col`), set `order_err`; the tile is still walked.
  - If `tile_rows_in` or `tile_cols_in` is 0, set `order_err`, discard the tile, and stay in ARMED.
  - Otherwise set `r=0`, `c=0`, `line = base + tile_row_idx*frame_W + tile_col_idx`, and go to WALK.
- **Address arithmetic:** the product is computed at 2*WIDTH, zero-extended, and summed modulo 2^ADDR_W.
- **WALK:**
  - `wr_valid=1` and `wr_addr = line + c`.
  - `wr_first = (r==0 && c==0)`; `wr_last = (r==rows-1 && c==cols-1)`.
  - On a handshake (`wr_valid && wr_ready`):
    - if `c < cols-1`, then `c++`;
    - else `c=0`, `r++`, `line += frame_W`.
- **End of tile** (handshake with `wr_last`):
  - `exp_col += cols`.
  - If `exp_col >= frame_W`: `exp_col = 0` and `exp_row += rows`.
  - If `exp_row` then reaches or exceeds `frame_H`: pulse `frame_done`, clear the FIFO, go to IDLE.
  - Otherwise go to ARMED.
- Comparisons use the updated values, computed at WIDTH+1 bits so they cannot wrap.
- Outputs hold stable while `wr_valid && !wr_ready`.

## Timing
- **Reset values:** all outputs 0 (`wr_valid`, `wr_addr`, `wr_first`, `wr_last`, `busy`, `frame_done`, `overflow`, `order_err`); state IDLE; FIFO empty; counters 0.
- **Start:** `start` sampled at edge E → `busy=1` after E.
- **First tile:** `tile_valid` at edge E (FIFO was empty, state ARMED) → pop at E+1 → `wr_valid=1` after E+1 (2-cycle latency).
- **Between tiles:** one bubble cycle (ARMED) between the `wr_last` handshake and the next tile's first `wr_valid`.
- **Throughput:** one pixel per cycle with `wr_ready=1`.
- **Frame end:** `frame_done` is high the cycle after the final handshake; `busy` drops in that same cycle.
- **Reset mid-operation:** asynchronously returns everything to reset values; the in-flight tile is lost.
- **Ignored inputs:** `start` while busy has no effect; `tile_valid` in IDLE has no effect.

## Test plan
- **Full frame:** frame 4x6, tiles 2x4, base 0x1000; tiles (0,0,2,4), (0,4,2,2), (2,0,2,4), (2,4,2,2) one per cycle, `wr_ready=1`.
  - Tile 1 addresses: 0x1000–0x1003, 0x1006–0x1009.
  - Tile 2 addresses: 0x1004, 0x1005, 0x100A, 0x100B.
  - 24 writes total; one `frame_done` pulse; `overflow=0`, `order_err=0`.
- **Backpressure:** same frame, `wr_ready` toggles 1,0,1,0.
  - Each address holds while stalled; no duplicates, no skips; still 24 writes.
- **Order error:** after `start`, send (2,0,2,4) first → `order_err=1` after the pop, and that tile's addresses begin at 0x100C.
- **Overflow:** `FIFO_DEPTH=4`, `wr_ready=0`, six descriptors pushed back-to-back.
  - The first is popped; descriptors 2–5 are stored; the 6th is dropped; `overflow=1` and stays 1 until the next `start`.
- **Zero size:** descriptor (0,0,0,4) → `order_err=1`, no writes, state remains ARMED.
- **Reset mid-walk:** assert `rst_n=0` during tile 1 → all outputs 0 immediately; after release, `start` plus the full sequence reproduces the full-frame scenario.
